// File: rtl/axi4_pkg.sv
// axi4_pkg: AXI4 constants and the read-arbiter state type shared by the
// read-side arbiter and its round-robin picker.
package axi4_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker. Searches the request vector
// starting one slot after the previous winner, wrapping modulo N, and returns
// a one-hot grant plus the winning index. Supports N = 2..4.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last,
  output logic [N-1:0] grant,
  output logic [1:0]   idx,
  output logic         any
);

  logic [3:0] req_ext;
  logic [3:0] grant_ext;
  logic [2:0] cand;

  assign req_ext = 4'(req);

  // scan last+1, last+2, ... (mod N); the first requester found wins
  always_comb begin
    grant_ext = '0;
    idx       = '0;
    any       = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last} + 3'(k);
      if (cand >= 3'(N)) begin
        cand = cand - 3'(N);
      end
      if (!any && req_ext[cand[1:0]]) begin
        any                   = 1'b1;
        idx                   = cand[1:0];
        grant_ext[cand[1:0]]  = 1'b1;
      end
    end
  end

  assign grant = grant_ext[N-1:0];

endmodule

// File: rtl/axi4_rd_arbiter.sv
// axi4_rd_arbiter: shares one AXI4 read master port (AR + R) between N local
// requesters. One AR is granted at a time, tagged with arid = requester index;
// R beats are routed back per beat by rid. Each requester may have at most
// MAX_OUTST bursts in flight.
// Optional build macro AXI4_RD_ARB_PRIO_EN: requester 0, when eligible, beats
// the round-robin choice; the pointer still follows the actual winner.
module axi4_rd_arbiter
  import axi4_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic [N-1:0]          req_arvalid,
  output logic [N-1:0]          req_arready,
  input  logic [N*32-1:0]       req_araddr,
  input  logic [N*8-1:0]        req_arlen,
  input  logic [N*3-1:0]        req_arsize,
  output logic [N-1:0]          req_rvalid,
  input  logic [N-1:0]          req_rready,
  output logic [W-1:0]          req_rdata,
  output logic [1:0]            req_rresp,
  output logic                  req_rlast,
  output logic [AXI_ID_W-1:0]   arid,
  output logic [AXI_ADDR_W-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic [3:0]            arqos,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [AXI_ID_W-1:0]   rid,
  input  logic [W-1:0]          rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  busy,
  output logic                  rid_err
);

  arb_state_t state_reg, state_next;
  logic [1:0]  last_reg;
  logic [1:0]  arid_reg;
  logic [31:0] araddr_reg;
  logic [7:0]  arlen_reg;
  logic [2:0]  arsize_reg;
  logic        rid_err_reg;

  logic [N-1:0][31:0] addr_arr;
  logic [N-1:0][7:0]  len_arr;
  logic [N-1:0][2:0]  size_arr;
  logic [N-1:0]       elig;
  logic [N-1:0]       cnt_nz;

  logic [N-1:0] rr_grant;
  logic [1:0]   rr_idx;
  logic         rr_any;
  logic [N-1:0] win_grant;
  logic [1:0]   win_idx;
  logic         win_any;

  logic       rid_ok;
  logic       ar_hs;
  logic       r_done;
  logic [3:0] req_rready_ext;

  assign rid_ok         = rid < 4'(N);
  assign ar_hs          = arvalid && arready;
  assign r_done         = rvalid && rready && rlast && rid_ok;
  assign req_rready_ext = 4'(req_rready);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_req
      logic [3:0] cnt_reg;
      logic       inc;
      logic       dec;

      assign addr_arr[gi]   = req_araddr[gi*32 +: 32];
      assign len_arr[gi]    = req_arlen[gi*8 +: 8];
      assign size_arr[gi]   = req_arsize[gi*3 +: 3];
      assign elig[gi]       = req_arvalid[gi] && (cnt_reg < 4'(MAX_OUTST));
      assign cnt_nz[gi]     = |cnt_reg;
      assign req_rvalid[gi] = rvalid && (rid == 4'(gi));
      assign inc            = ar_hs && (arid_reg == 2'(gi));
      assign dec            = r_done && (rid == 4'(gi));

      // outstanding-burst counter: +1 on AR handshake, -1 on last beat, net 0 when both
      always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
          cnt_reg <= '0;
        end else if (inc && !dec) begin
          cnt_reg <= cnt_reg + 4'd1;
        end else if (dec && !inc && cnt_reg != 4'd0) begin
          cnt_reg <= cnt_reg - 4'd1;
        end
      end

      // a completion with nothing outstanding means the slave misbehaved
      assert property (@(posedge aclk) disable iff (!areset_n)
                       !(dec && !inc && cnt_reg == 4'd0));
    end
  endgenerate

  rr_pick #(.N(N)) u_rr_pick (
    .req   (elig),
    .last  (last_reg),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

`ifdef AXI4_RD_ARB_PRIO_EN
  assign win_any   = rr_any;
  assign win_idx   = elig[0] ? 2'd0 : rr_idx;
  assign win_grant = elig[0] ? N'(1) : rr_grant;
`else
  assign win_any   = rr_any;
  assign win_idx   = rr_idx;
  assign win_grant = rr_grant;
`endif

  // arbitration state register
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // next state and the one-cycle accept strobe to the winning requester
  always_comb begin
    state_next  = state_reg;
    req_arready = '0;
    case (state_reg)
      IDLE: begin
        if (win_any && areset_n) begin
          req_arready = win_grant;
          state_next  = GRANT;
        end
      end
      GRANT: begin
        if (arready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // capture the winner's AR payload and move the round-robin pointer to it
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      araddr_reg <= '0;
      arlen_reg  <= '0;
      arsize_reg <= '0;
      arid_reg   <= '0;
      last_reg   <= 2'(N - 1);
    end else if (state_reg == IDLE && win_any) begin
      araddr_reg <= addr_arr[win_idx];
      arlen_reg  <= len_arr[win_idx];
      arsize_reg <= size_arr[win_idx];
      arid_reg   <= win_idx;
      last_reg   <= win_idx;
    end
  end

  // flag beats carrying an ID no requester owns (they are sunk via rready=1)
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rid_err_reg <= 1'b0;
    end else begin
      rid_err_reg <= rvalid && !rid_ok;
    end
  end

  assign arvalid   = (state_reg == GRANT);
  assign arid      = {2'b00, arid_reg};
  assign araddr    = araddr_reg;
  assign arlen     = arlen_reg;
  assign arsize    = arsize_reg;
  assign arburst   = BURST_INCR;
  assign arlock    = 1'b0;
  assign arcache   = 4'd0;
  assign arprot    = 3'd0;
  assign arqos     = 4'd0;

  assign rready    = rid_ok ? req_rready_ext[rid[1:0]] : 1'b1;
  assign req_rdata = rdata;
  assign req_rresp = rresp;
  assign req_rlast = rlast;

  assign busy      = (|cnt_nz) || arvalid;
  assign rid_err   = rid_err_reg;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// tb_axi4_rd_arbiter: self-checking bench for axi4_rd_arbiter (N=4,
// MAX_OUTST=2). Expected AR payloads are queued as requests are driven and
// popped by the AR monitor on each handshake.
module tb_axi4_rd_arbiter;
  import axi4_pkg::*;

  localparam int N         = 4;
  localparam int W         = 32;
  localparam int MAX_OUTST = 2;

  logic           aclk = 1'b0;
  logic           areset_n;
  logic [N-1:0]   req_arvalid, req_arready, req_rvalid, req_rready;
  logic [N*32-1:0] req_araddr;
  logic [N*8-1:0] req_arlen;
  logic [N*3-1:0] req_arsize;
  logic [W-1:0]   req_rdata, rdata;
  logic [1:0]     req_rresp, rresp, arburst;
  logic           req_rlast, rlast, rvalid, rready, arvalid, arready, arlock;
  logic [3:0]     arid, rid, arcache, arqos;
  logic [31:0]    araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize, arprot;
  logic           busy, rid_err;

  always #5 aclk = ~aclk;

  axi4_rd_arbiter #(.N(N), .W(W), .MAX_OUTST(MAX_OUTST)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .req_arvalid(req_arvalid), .req_arready(req_arready),
    .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arsize(req_arsize),
    .req_rvalid(req_rvalid), .req_rready(req_rready),
    .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arqos(arqos), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .busy(busy), .rid_err(rid_err)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_exp_t;

  ar_exp_t ar_q[$];
  ar_exp_t ar_e;
  int      ar_cycles[$];

  always @(posedge aclk) cycle <= cycle + 1;

  // AR scoreboard: pop and compare on every handshake
  always @(negedge aclk) begin
    if (areset_n && arvalid && arready) begin
      checks++;
      if (ar_q.size() == 0) begin
        errors++;
        $display("FAIL ar_unexpected got id=%0d addr=%h, required no AR", arid, araddr);
      end else begin
        ar_e = ar_q.pop_front();
        if ({arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos} !==
            {ar_e.id, ar_e.addr, ar_e.len, ar_e.size, BURST_INCR, 1'b0, 4'd0, 3'd0, 4'd0}) begin
          errors++;
          $display("FAIL ar_payload got id=%0d addr=%h len=%0d size=%0d burst=%b, required id=%0d addr=%h len=%0d size=%0d burst=01",
                   arid, araddr, arlen, arsize, arburst, ar_e.id, ar_e.addr, ar_e.len, ar_e.size);
        end else begin
          $display("AR  id=%0d addr=%h len=%0d size=%0d cycle=%0d", arid, araddr, arlen, arsize, cycle);
        end
      end
      ar_cycles.push_back(cycle);
    end
  end

  // one line per R beat accepted
  always @(negedge aclk) begin
    if (areset_n && rvalid && rready)
      $display("R   rid=%0d data=%h last=%b req_rvalid=%b", rid, rdata, rlast, req_rvalid);
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    areset_n = 1'b0;
    req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_arsize = '0;
    req_rready = '1; arready = 1'b1;
    rvalid = 1'b0; rid = '0; rdata = '0; rresp = RESP_OKAY; rlast = 1'b0;
    ar_q.delete();
    repeat (3) @(posedge aclk);
    #1 areset_n = 1'b1;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] data, input logic last);
    rvalid = 1'b1; rid = id; rdata = data; rlast = last;
    @(posedge aclk); #1;
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    areset_n = 1'b0;
    req_arvalid = 4'b1111;
    @(negedge aclk);
    checks++;
    if ({arvalid, req_arready, rid_err, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got arvalid=%b req_arready=%b rid_err=%b busy=%b, required all 0",
               arvalid, req_arready, rid_err, busy);
    end
    checks++;
    if ({arid, araddr, arlen, arsize} !== 47'd0) begin
      errors++;
      $display("FAIL reset_payload got id=%0d addr=%h len=%0d size=%0d, required 0", arid, araddr, arlen, arsize);
    end
    req_arvalid = '0;
    @(posedge aclk); #1 areset_n = 1'b1;
    $display("reset test done");
  endtask

  task automatic test_single();
    do_reset();
    ar_q.push_back('{4'd0, 32'h1000, 8'd3, 3'd2});
    req_araddr[31:0] = 32'h1000; req_arlen[7:0] = 8'd3; req_arsize[2:0] = 3'd2;
    req_arvalid = 4'b0001;
    @(negedge aclk);
    checks++;
    if (req_arready !== 4'b0001 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_accept got req_arready=%b arvalid=%b, required 0001/0", req_arready, arvalid);
    end
    @(posedge aclk); #1 req_arvalid = '0;
    @(negedge aclk);
    checks++;
    if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h1000) begin
      errors++;
      $display("FAIL single_latency got arvalid=%b arid=%0d araddr=%h, required 1/0/00001000", arvalid, arid, araddr);
    end
    @(posedge aclk); #1;
    rresp = RESP_EXOKAY;
    for (int b = 0; b < 4; b++) begin
      rvalid = 1'b1; rid = 4'd0; rdata = 32'hA000 + 32'(b); rlast = (b == 3);
      @(negedge aclk);
      checks++;
      if (req_rvalid !== 4'b0001 || rready !== 1'b1 || req_rdata !== 32'hA000 + 32'(b) ||
          req_rlast !== (b == 3) || req_rresp !== RESP_EXOKAY || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_beat%0d got req_rvalid=%b rready=%b data=%h last=%b resp=%b busy=%b, required 0001/1/%h/%b/01/1",
                 b, req_rvalid, rready, req_rdata, req_rlast, req_rresp, busy, 32'hA000 + 32'(b), (b == 3));
      end
      @(posedge aclk); #1;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = RESP_OKAY;
    @(negedge aclk);
    checks++;
    if (busy !== 1'b0 || req_rvalid !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle got busy=%b req_rvalid=%b, required 0/0000", busy, req_rvalid);
    end
  endtask

  task automatic test_rr_order();
    int k;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    ar_cycles.delete();
    for (int i = 0; i < 5; i++)
      ar_q.push_back('{4'(order[i]), 32'h2000 + 32'(order[i]) * 32'h100, 8'(order[i]), 3'(order[i])});
    for (int i = 0; i < N; i++) begin
      req_araddr[i*32 +: 32] = 32'h2000 + 32'(i) * 32'h100;
      req_arlen[i*8 +: 8]    = 8'(i);
      req_arsize[i*3 +: 3]   = 3'(i);
    end
    req_arvalid = 4'b1111;
    k = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      @(negedge aclk);
      if (req_arready != '0) begin
        checks++;
        if (req_arready !== (4'b0001 << order[k])) begin
          errors++;
          $display("FAIL rr_grant%0d got %b, required %b", k, req_arready, 4'b0001 << order[k]);
        end
        k++;
        if (k == 5) begin
          @(posedge aclk); #1 req_arvalid = '0;
        end
      end
    end
    checks++;
    if (k != 5) begin
      errors++;
      $display("FAIL rr_count got %0d grants, required 5", k);
    end
    for (int c = 0; c < 20 && ar_q.size() != 0; c++) @(negedge aclk);
    checks++;
    if (ar_cycles.size() != 5) begin
      errors++;
      $display("FAIL rr_ar_count got %0d AR handshakes, required 5", ar_cycles.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (ar_cycles[i] - ar_cycles[i-1] != 2) begin
          errors++;
          $display("FAIL rr_spacing%0d got %0d cycles, required 2", i, ar_cycles[i] - ar_cycles[i-1]);
        end
      end
    end
    @(posedge aclk); #1;
    r_beat(4'd0, 32'h20, 1'b1); r_beat(4'd0, 32'h21, 1'b1);
    r_beat(4'd1, 32'h22, 1'b1); r_beat(4'd2, 32'h23, 1'b1); r_beat(4'd3, 32'h24, 1'b1);
    @(negedge aclk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_max_outst();
    int k;
    do_reset();
    ar_q.push_back('{4'd1, 32'h3000, 8'd7, 3'd2});
    ar_q.push_back('{4'd1, 32'h3000, 8'd7, 3'd2});
    req_araddr[32 +: 32] = 32'h3000; req_arlen[8 +: 8] = 8'd7; req_arsize[3 +: 3] = 3'd2;
    req_arvalid = 4'b0010;
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      @(negedge aclk);
      if (req_arready[1]) k++;
    end
    checks++;
    if (k != 2) begin
      errors++;
      $display("FAIL max_first_two got %0d grants, required 2", k);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      checks++;
      if (req_arready !== 4'b0000) begin
        errors++;
        $display("FAIL max_blocked%0d got req_arready=%b, required 0000", c, req_arready);
      end
    end
    @(posedge aclk); #1;
    ar_q.push_back('{4'd1, 32'h3000, 8'd7, 3'd2});
    r_beat(4'd1, 32'h31, 1'b1);
    @(negedge aclk);
    checks++;
    if (req_arready !== 4'b0010) begin
      errors++;
      $display("FAIL max_release got req_arready=%b, required 0010", req_arready);
    end
    @(posedge aclk); #1 req_arvalid = '0;
    for (int c = 0; c < 20 && ar_q.size() != 0; c++) @(negedge aclk);
    checks++;
    if (ar_q.size() != 0) begin
      errors++;
      $display("FAIL max_ar_timeout got %0d pending, required 0", ar_q.size());
    end
    @(posedge aclk); #1;
    r_beat(4'd1, 32'h32, 1'b1); r_beat(4'd1, 32'h33, 1'b1);
    @(negedge aclk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL max_drain got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    ar_q.push_back('{4'd2, 32'h4000, 8'd0, 3'd2});
    req_araddr[64 +: 32] = 32'h4000; req_arlen[16 +: 8] = 8'd0; req_arsize[6 +: 3] = 3'd2;
    req_arvalid = 4'b0100;
    @(negedge aclk);
    checks++;
    if (req_arready !== 4'b0100) begin
      errors++;
      $display("FAIL same_grant_a got %b, required 0100", req_arready);
    end
    @(posedge aclk); #1 req_arvalid = '0;
    @(posedge aclk); #1;
    ar_q.push_back('{4'd2, 32'h4100, 8'd0, 3'd2});
    req_araddr[64 +: 32] = 32'h4100; arready = 1'b0; req_arvalid = 4'b0100;
    @(negedge aclk);
    checks++;
    if (req_arready !== 4'b0100) begin
      errors++;
      $display("FAIL same_grant_b got %b, required 0100", req_arready);
    end
    @(posedge aclk); #1 req_arvalid = '0;
    @(posedge aclk); #1;
    arready = 1'b1; rvalid = 1'b1; rid = 4'd2; rlast = 1'b1; rdata = 32'h40;
    @(negedge aclk);
    checks++;
    if (arvalid !== 1'b1 || req_rvalid !== 4'b0100 || rready !== 1'b1) begin
      errors++;
      $display("FAIL same_overlap got arvalid=%b req_rvalid=%b rready=%b, required 1/0100/1", arvalid, req_rvalid, rready);
    end
    @(posedge aclk); #1 rvalid = 1'b0; rlast = 1'b0;
    ar_q.push_back('{4'd2, 32'h4200, 8'd0, 3'd2});
    req_araddr[64 +: 32] = 32'h4200; req_arvalid = 4'b0100;
    @(negedge aclk);
    checks++;
    if (busy !== 1'b1 || req_arready !== 4'b0100) begin
      errors++;
      $display("FAIL same_net_zero got busy=%b req_arready=%b, required 1/0100", busy, req_arready);
    end
    @(posedge aclk); #1 req_arvalid = '0;
    @(posedge aclk); #1;
    r_beat(4'd2, 32'h41, 1'b1);
    @(negedge aclk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL same_one_left got busy=%b, required 1", busy);
    end
    @(posedge aclk); #1;
    r_beat(4'd2, 32'h42, 1'b1);
    @(negedge aclk);
    checks++;
    if (busy !== 1'b0 || ar_q.size() != 0) begin
      errors++;
      $display("FAIL same_drain got busy=%b pending_ar=%0d, required 0/0", busy, ar_q.size());
    end
  endtask

  task automatic test_bad_rid();
    do_reset();
    req_rready = 4'b1000;
    rvalid = 1'b1; rid = 4'd3; rdata = 32'h70;
    @(negedge aclk);
    checks++;
    if (rready !== 1'b1 || req_rvalid !== 4'b1000) begin
      errors++;
      $display("FAIL rid3_route got rready=%b req_rvalid=%b, required 1/1000", rready, req_rvalid);
    end
    @(posedge aclk); #1 rid = 4'd2;
    @(negedge aclk);
    checks++;
    if (rready !== 1'b0 || req_rvalid !== 4'b0100) begin
      errors++;
      $display("FAIL rid2_stall got rready=%b req_rvalid=%b, required 0/0100", rready, req_rvalid);
    end
    @(posedge aclk); #1 rid = 4'd7; req_rready = 4'b0000;
    @(negedge aclk);
    checks++;
    if (rready !== 1'b1 || req_rvalid !== 4'b0000 || rid_err !== 1'b0) begin
      errors++;
      $display("FAIL rid7_sink got rready=%b req_rvalid=%b rid_err=%b, required 1/0000/0", rready, req_rvalid, rid_err);
    end
    @(posedge aclk); #1 rvalid = 1'b0;
    @(negedge aclk);
    checks++;
    if (rid_err !== 1'b1) begin
      errors++;
      $display("FAIL rid7_err got rid_err=%b, required 1", rid_err);
    end
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++;
    if (rid_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rid7_pulse got rid_err=%b busy=%b, required 0/0", rid_err, busy);
    end
    req_rready = '1;
  endtask

  task automatic test_prio();
    int k;
`ifdef AXI4_RD_ARB_PRIO_EN
    int order[4] = '{0, 0, 3, 3};
`else
    int order[4] = '{0, 3, 0, 3};
`endif
    do_reset();
    for (int i = 0; i < 4; i++)
      ar_q.push_back('{4'(order[i]), 32'h5000 + 32'(order[i]) * 32'h100, 8'd1, 3'd2});
    req_araddr[0 +: 32] = 32'h5000; req_araddr[96 +: 32] = 32'h5300;
    req_arlen[0 +: 8] = 8'd1; req_arlen[24 +: 8] = 8'd1;
    req_arsize[0 +: 3] = 3'd2; req_arsize[9 +: 3] = 3'd2;
    req_arvalid = 4'b1001;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge aclk);
      if (req_arready != '0) begin
        checks++;
        if (req_arready !== (4'b0001 << order[k])) begin
          errors++;
          $display("FAIL prio_grant%0d got %b, required %b", k, req_arready, 4'b0001 << order[k]);
        end
        k++;
      end
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      checks++;
      if (req_arready !== 4'b0000) begin
        errors++;
        $display("FAIL prio_masked%0d got %b, required 0000", c, req_arready);
      end
    end
    checks++;
    if (k != 4 || ar_q.size() != 0) begin
      errors++;
      $display("FAIL prio_count got %0d grants pending_ar=%0d, required 4/0", k, ar_q.size());
    end
    // reset with bursts still outstanding: all tracking is dropped
    areset_n = 1'b0;
    @(negedge aclk);
    checks++;
    if (busy !== 1'b0 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL midreset got busy=%b arvalid=%b, required 0/0", busy, arvalid);
    end
    @(posedge aclk); #1 areset_n = 1'b1;
    ar_q.push_back('{4'd0, 32'h5000, 8'd1, 3'd2});
    @(negedge aclk);
    checks++;
    if (req_arready !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_regrant got %b, required 0001", req_arready);
    end
    @(posedge aclk); #1 req_arvalid = '0;
    for (int c = 0; c < 20 && ar_q.size() != 0; c++) @(negedge aclk);
    checks++;
    if (ar_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_ar got %0d pending, required 0", ar_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_max_outst();
    test_same_cycle();
    test_bad_rid();
    test_prio();
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_rd_arbiter.md
Name: axi4_rd_arbiter

Overview:
Round-robin arbiter that shares one AXI4 master read port (AR and R channels) between N local requesters.
- Grants one AR request at a time and tags it with arid = requester index.
- Tracks outstanding bursts per requester and routes R beats back by rid.
- Sits between requester engines (DMA, cache refill) and the AXI4 master port; the write side is out of scope.

Parameters:
N, 4, number of requesters (2..4).
W, 32, data width in bits.
MAX_OUTST, 4, maximum outstanding read bursts per requester (1..15).

Ports:
aclk  in  1  clock.
areset_n  in  1  asynchronous reset, active low.
req_arvalid  in  N  request valid, one bit per requester.
req_arready  out  N  request accepted; one-cycle pulse.
req_araddr  in  N*32  start address; requester i at [i*32+:32].
req_arlen  in  N*8  beats minus 1; requester i at [i*8+:8].
req_arsize  in  N*3  beat size, 2^n bytes; requester i at [i*3+:3].
req_rvalid  out  N  R beat valid for requester i.
req_rready  in  N  requester i accepts the R beat.
req_rdata  out  W  broadcast copy of rdata.
req_rresp  out  2  broadcast copy of rresp.
req_rlast  out  1  broadcast copy of rlast.
arid  out  4  requester index, zero-extended.
araddr  out  32  registered address.
arlen  out  8  registered burst length.
arsize  out  3  registered beat size.
arburst  out  2  constant 2'b01 (INCR).
arlock, arcache, arprot, arqos  out  1/4/3/4  constant 0.
arvalid  out  1  AR valid.
arready  in  1  AR ready from the slave.
rid  in  4  R ID.
rdata  in  W  read data.
rresp  in  2  read response.
rlast  in  1  last beat of burst.
rvalid  in  1  R valid.
rready  out  1  R ready.
busy  out  1  any outstanding count is non-zero, or arvalid is high.
rid_err  out  1  one-cycle pulse when a beat arrives with rid >= N.

Behaviour:
- Reset, asynchronous and active low, forces:
  - state IDLE; arvalid 0; req_arready 0; rid_err 0;
  - AR payload registers 0; all outstanding counters 0;
  - round-robin pointer last = N-1, so requester 0 wins first.
- FSM IDLE: eligible[i] = req_arvalid[i] && (cnt[i] < MAX_OUTST).
  - Winner = first eligible index searching last+1, last+2, ... modulo N.
  - If any eligible, in the same cycle: req_arready[winner] pulses; araddr/arlen/arsize latch the winner's fields; arid <= winner; last <= winner; next state GRANT.
- FSM GRANT: arvalid = 1; payload held stable until arready.
  - On arvalid && arready: cnt[arid]++ and next state IDLE.
  - Throughput: at most one AR per 2 cycles.
  - Latency: request visible at cycle t -> arvalid high at t+1.
- A requester with cnt[i] == MAX_OUTST is masked from arbitration until one of its bursts completes.
- R routing is combinational:
  - req_rvalid[i] = rvalid && (rid == i).
  - rready = req_rready[rid] when rid < N, else 1 (the beat is sunk and rid_err pulses registered the next cycle).
- Burst completion: rvalid && rready && rlast && rid < N -> cnt[rid]--.
- Simultaneous AR handshake and completion for the same requester leave the counter unchanged (net 0).
- Counter never underflows: a decrement at cnt == 0 is ignored; assertion only.
- Interleaved R bursts from different IDs are legal; routing is per beat.
- Reset mid-burst discards all tracking; the slave must also be reset.

Optional Feature:
AXI4_RD_ARB_PRIO_EN
- Defined: requester 0, when eligible, always wins over the round-robin choice; the pointer still updates to the actual winner.
- Undefined: pure round-robin, as above.

Decomposition:
- Package axi4_pkg holds:
  - BURST_INCR = 2'b01;
  - AXI ID/ADDR width constants (4/32);
  - RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - arb state enum {IDLE, GRANT}.
- One sub-module, rr_pick: N-bit request vector plus pointer -> one-hot grant and index; combinational and reusable by the write-side arbiter.

Test Plan:
- Reset, then req_arvalid = 4'b0001, araddr0 = 0x1000, arlen0 = 3 -> arvalid at t+1, arid = 0, araddr = 0x1000; 4 R beats rid = 0 -> only req_rvalid[0] toggles; busy falls after rlast.
- req_arvalid = 4'b1111 held, arready = 1 -> grant order 0,1,2,3,0; one AR every 2 cycles.
- MAX_OUTST = 2; requester 1 issues 3 requests with no R returned -> third req_arready[1] withheld; a completion (rlast, rid = 1) releases it the next IDLE cycle.
- AR handshake for requester 2 in the same cycle as its rlast beat -> cnt[2] unchanged.
- rvalid with rid = 7 -> rready = 1, no req_rvalid, rid_err pulses once.
- AXI4_RD_ARB_PRIO_EN defined, req_arvalid = 4'b1001 held -> requester 0 granted every time while eligible.
